// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// ctrl_t bundles every pipeline-control output so each decode case is a single constant.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic dmem_req;
        logic pc_write;
        logic pc_sel_branch;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic exmem_flush;
        logic memwb_bubble;
    } ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // dmem_req is left 0 in every constant; the top ORs in the request separately.
    localparam ctrl_t CTRL_RESET = '{dmem_req: 1'b0, pc_write: 1'b0, pc_sel_branch: 1'b0,
                                     ifid_write: 1'b0, ifid_flush: 1'b1, idex_write: 1'b0,
                                     idex_flush: 1'b1, exmem_write: 1'b0, exmem_flush: 1'b1,
                                     memwb_bubble: 1'b1};
    localparam ctrl_t CTRL_NORMAL = '{dmem_req: 1'b0, pc_write: 1'b1, pc_sel_branch: 1'b0,
                                      ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
                                      idex_flush: 1'b0, exmem_write: 1'b1, exmem_flush: 1'b0,
                                      memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{dmem_req: 1'b0, pc_write: 1'b0, pc_sel_branch: 1'b0,
                                      ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
                                      idex_flush: 1'b0, exmem_write: 1'b0, exmem_flush: 1'b0,
                                      memwb_bubble: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{dmem_req: 1'b0, pc_write: 1'b1, pc_sel_branch: 1'b1,
                                      ifid_write: 1'b1, ifid_flush: 1'b1, idex_write: 1'b1,
                                      idex_flush: 1'b1, exmem_write: 1'b1, exmem_flush: 1'b1,
                                      memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_LOADUSE = '{dmem_req: 1'b0, pc_write: 1'b0, pc_sel_branch: 1'b0,
                                       ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b1,
                                       idex_flush: 1'b1, exmem_write: 1'b1, exmem_flush: 1'b0,
                                       memwb_bubble: 1'b0};

    function automatic logic loaduse_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic       use_rs1,
        input logic [4:0] rs1,
        input logic       use_rs2,
        input logic [4:0] rs2
    );
        return memread && (rd != REG_ZERO) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, variable-latency
// data-memory freeze with timeout abort, and taken-branch redirect from EX/MEM.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             dbg_state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_e  state;
    logic [7:0] wait_cnt;
    logic       memop;
    logic       taken;
    logic       loaduse;
    logic       frozen;
    logic       timeout_hit;
    ctrl_t      ctrl;

    assign memop       = exmem_memread | exmem_memwrite;
    assign taken       = exmem_branch & exmem_zero;
    assign loaduse     = loaduse_hit(idex_memread, idex_rd, ifid_use_rs1, ifid_rs1,
                                     ifid_use_rs2, ifid_rs2);
    assign timeout_hit = (state == ST_MEM_WAIT) && !dmem_ready && (wait_cnt == WAIT_LAST);
    assign frozen      = ((state == ST_RUN) && memop && !dmem_ready) ||
                         ((state == ST_MEM_WAIT) && !dmem_ready);

    // The abort cycle stays frozen but clears EX/MEM so the dead access never retires.
    always_comb begin
        ctrl = CTRL_NORMAL;
        if (!reset) begin
            ctrl = CTRL_RESET;
        end else begin
            if (frozen) begin
                ctrl = CTRL_FREEZE;
                if (timeout_hit) begin
                    ctrl.exmem_flush = 1'b1;
                end
            end else if (taken) begin
                ctrl = CTRL_BRANCH;
            end else if (loaduse) begin
                ctrl = CTRL_LOADUSE;
            end
            ctrl.dmem_req = (state == ST_MEM_WAIT) | memop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (memop && !dmem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= ST_RUN;
                        wait_cnt    <= 8'd0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!ctrl.pc_write),
        .count (stall_cycles)
    );

    assign dmem_req      = ctrl.dmem_req;
    assign pc_write      = ctrl.pc_write;
    assign pc_sel_branch = ctrl.pc_sel_branch;
    assign ifid_write    = ctrl.ifid_write;
    assign ifid_flush    = ctrl.ifid_flush;
    assign idex_write    = ctrl.idex_write;
    assign idex_flush    = ctrl.idex_flush;
    assign exmem_write   = ctrl.exmem_write;
    assign exmem_flush   = ctrl.exmem_flush;
    assign memwb_bubble  = ctrl.memwb_bubble;
    assign dbg_state     = state;

endmodule
